// File: rtl/bytecode_loader_pkg.sv
// Shared encodings and defaults for the UART bytecode loader.
package bytecode_loader_pkg;

  localparam int          CLKS_PER_BIT_DEFAULT = 217;
  localparam int          MEM_DEPTH_DEFAULT    = 111;
  localparam logic [7:0]  SYNC_BYTE_DEFAULT    = 8'hA5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4
  } frame_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_BITS  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchronizer, half-bit start re-check, centre sampling.
module uart_rx_byte
  import bytecode_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int              CW      = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]   HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic            sync1;
  logic            sync2;
  logic            rx_prev;
  rx_state_t       rx_state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      sync1      <= rx;
      sync2      <= sync1;
      rx_prev    <= sync2;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          cnt <= '0;
          if (rx_prev && !sync2) rx_state <= RX_START;
        end
        RX_START: begin
          // A line back high at mid start bit is a glitch, not a frame.
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            rx_state <= sync2 ? RX_IDLE : RX_BITS;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_BITS: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            shift   <= {sync2, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL_M1) begin
            cnt      <= '0;
            rx_state <= RX_IDLE;
            if (sync2) begin
              byte_valid <= 1'b1;
              byte_data  <= shift;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/bytecode_loader.sv
// Frame FSM writing UART-delivered bytecode into RAM while holding the CPU in reset.
// Define BYTECODE_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module bytecode_loader
  import bytecode_loader_pkg::*;
#(
  parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int         MEM_DEPTH    = MEM_DEPTH_DEFAULT,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       cpu_hold,
  output logic       done,
  output logic       err
);

  localparam logic [8:0] DEPTH9 = MEM_DEPTH[8:0];

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  // state is the observation point for the frame FSM.
  frame_state_t state;
  logic [7:0]   addr;
  logic [8:0]   count;
  logic         in_range;
`ifdef BYTECODE_LOADER_CHECKSUM_EN
  logic [7:0]   acc;
`endif

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  assign in_range = ({1'b0, addr} < DEPTH9);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      count     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef BYTECODE_LOADER_CHECKSUM_EN
      acc       <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      if (frame_err) begin
        err   <= 1'b1;
        state <= IDLE;
      end else if (byte_valid) begin
        case (state)
          IDLE: begin
            if (byte_data == SYNC_BYTE) begin
              state    <= ADDR;
              cpu_hold <= 1'b1;
              err      <= 1'b0;
`ifdef BYTECODE_LOADER_CHECKSUM_EN
              acc      <= '0;
`endif
            end
          end
          ADDR: begin
            addr  <= byte_data;
            state <= LEN;
`ifdef BYTECODE_LOADER_CHECKSUM_EN
            acc   <= acc + byte_data;
`endif
          end
          LEN: begin
            count <= (byte_data == 8'd0) ? 9'd256 : {1'b0, byte_data};
            state <= DATA;
`ifdef BYTECODE_LOADER_CHECKSUM_EN
            acc   <= acc + byte_data;
`endif
          end
          DATA: begin
            if (in_range) begin
              mem_we    <= 1'b1;
              mem_addr  <= addr;
              mem_wdata <= byte_data;
            end else begin
              err <= 1'b1;
            end
            addr  <= addr + 8'd1;
            count <= count - 9'd1;
`ifdef BYTECODE_LOADER_CHECKSUM_EN
            acc   <= acc + byte_data;
            if (count == 9'd1) state <= CSUM;
`else
            if (count == 9'd1) begin
              state <= IDLE;
              if (!err && in_range) begin
                done     <= 1'b1;
                cpu_hold <= 1'b0;
              end
            end
`endif
          end
          CSUM: begin
            state <= IDLE;
`ifdef BYTECODE_LOADER_CHECKSUM_EN
            if (!err && (acc + byte_data == 8'd0)) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              err <= 1'b1;
            end
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bytecode_loader.sv
// Directed bench for bytecode_loader: UART driver, write scoreboard, status checks.
module tb_bytecode_loader;
  import bytecode_loader_pkg::*;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       done;
  logic       err;

  logic [15:0] exp_q[$];
  logic [7:0]  tx_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          done_seen = 0;
  int          exp_done = 0;
  logic        prev_we = 1'b0;

  bytecode_loader #(.CLKS_PER_BIT(CPB), .MEM_DEPTH(111), .SYNC_BYTE(8'hA5)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
    rx = 1'b1;
    tick(2 * CPB);
  endtask

  task automatic send_q();
    while (tx_q.size() > 0) send_byte(tx_q.pop_front(), 1'b1);
  endtask

  // Appends the byte that makes ADDR+LEN+data+CSUM sum to zero (sync excluded).
  task automatic add_csum();
    logic [7:0] s;
    s = 8'd0;
    for (int i = 1; i < tx_q.size(); i++) s = s + tx_q[i];
    tx_q.push_back(8'd0 - s);
  endtask

  task automatic expect_write(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  // Monitor: every write strobe is matched against the scoreboard queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) begin
        check("we_spacing", {31'd0, prev_we}, 32'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected none", mem_addr, mem_wdata);
        end else begin
          check("write", {16'd0, mem_addr, mem_wdata}, {16'd0, exp_q.pop_front()});
        end
      end
      if (done) begin
        done_seen++;
        check("hold_at_done", {31'd0, cpu_hold}, 32'd0);
      end
    end
    prev_we = mem_we;
  end

  initial begin
    tick(3);
    @(negedge clk);
    check("rst_we", {31'd0, mem_we}, 0);
    check("rst_addr", {24'd0, mem_addr}, 0);
    check("rst_wdata", {24'd0, mem_wdata}, 0);
    check("rst_hold", {31'd0, cpu_hold}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_err", {31'd0, err}, 0);
    check("rst_state", {29'd0, dut.state}, {29'd0, IDLE});
    reset = 1'b0;
    tick(4);

    // Frame 1: three writes from 0x10.
    send_byte(8'hA5, 1'b1);
    check("f1_hold_after_sync", {31'd0, cpu_hold}, 1);
    tx_q = '{8'h10, 8'h03, 8'h07, 8'h00, 8'h2A};
`ifdef BYTECODE_LOADER_CHECKSUM_EN
    tx_q.push_front(8'hA5);
    add_csum();
    void'(tx_q.pop_front());
`endif
    expect_write(8'h10, 8'h07);
    expect_write(8'h11, 8'h00);
    expect_write(8'h12, 8'h2A);
    exp_done++;
    send_q();
    check("f1_done", done_seen, exp_done);
    check("f1_hold", {31'd0, cpu_hold}, 0);
    check("f1_err", {31'd0, err}, 0);

    // Frame 2: noise bytes ignored, then one write at 0x00.
    send_byte(8'h33, 1'b1);
    check("f2_noise_hold_33", {31'd0, cpu_hold}, 0);
    send_byte(8'hFF, 1'b1);
    check("f2_noise_hold_ff", {31'd0, cpu_hold}, 0);
    tx_q = '{8'hA5, 8'h00, 8'h01, 8'h5A};
`ifdef BYTECODE_LOADER_CHECKSUM_EN
    add_csum();
`endif
    expect_write(8'h00, 8'h5A);
    exp_done++;
    send_q();
    check("f2_done", done_seen, exp_done);
    check("f2_hold", {31'd0, cpu_hold}, 0);

    // Frame 3: runs past the end of RAM.
    tx_q = '{8'hA5, 8'h6D, 8'h03, 8'h11, 8'h22, 8'h33};
`ifdef BYTECODE_LOADER_CHECKSUM_EN
    add_csum();
`endif
    expect_write(8'h6D, 8'h11);
    expect_write(8'h6E, 8'h22);
    send_q();
    check("f3_err", {31'd0, err}, 1);
    check("f3_hold", {31'd0, cpu_hold}, 1);
    check("f3_no_done", done_seen, exp_done);

    // Recovery frame clears err and releases hold.
    tx_q = '{8'hA5, 8'h20, 8'h01, 8'h77};
`ifdef BYTECODE_LOADER_CHECKSUM_EN
    add_csum();
`endif
    expect_write(8'h20, 8'h77);
    exp_done++;
    send_q();
    check("rec_err", {31'd0, err}, 0);
    check("rec_hold", {31'd0, cpu_hold}, 0);
    check("rec_done", done_seen, exp_done);

    // Framing error on the byte after sync.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h55, 1'b0);
    check("ferr_err", {31'd0, err}, 1);
    check("ferr_state", {29'd0, dut.state}, {29'd0, IDLE});
    check("ferr_hold", {31'd0, cpu_hold}, 1);

`ifdef BYTECODE_LOADER_CHECKSUM_EN
    // Bad checksum: data lands but the frame is rejected.
    tx_q = '{8'hA5, 8'h00, 8'h01, 8'h5A, 8'h00};
    expect_write(8'h00, 8'h5A);
    send_q();
    check("csum_err", {31'd0, err}, 1);
    check("csum_hold", {31'd0, cpu_hold}, 1);
    check("csum_no_done", done_seen, exp_done);
`endif

    // A new sync clears the sticky error.
    send_byte(8'hA5, 1'b1);
    check("sync_clears_err", {31'd0, err}, 0);
    check("sync_sets_hold", {31'd0, cpu_hold}, 1);

    // Reset mid-DATA of a 5-byte frame after two bytes.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    tx_q = '{8'hA5, 8'h40, 8'h05, 8'h01, 8'h02};
    expect_write(8'h40, 8'h01);
    expect_write(8'h41, 8'h02);
    send_q();
    check("mid_hold_before", {31'd0, cpu_hold}, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid_hold_after_rst", {31'd0, cpu_hold}, 0);
    tx_q = '{8'h03, 8'h04, 8'h05};
    send_q();
    check("mid_tail_hold", {31'd0, cpu_hold}, 0);
    check("mid_tail_err", {31'd0, err}, 0);
    check("mid_tail_done", done_seen, exp_done);

    tick(4);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
